// File: rtl/code_queue_pkg.sv
// code_pkg: shared definitions for the instruction queue and for decode.
// Holds the instruction word width, the bit positions and widths of the
// five instruction fields, and the struct that carries a split word.
package code_pkg;

    localparam int IW = 16;

    localparam int OP1_MSB    = 15;
    localparam int OP1_LSB    = 14;
    localparam int RA_MSB     = 13;
    localparam int RA_LSB     = 11;
    localparam int RD_MSB     = 10;
    localparam int RD_LSB     = 8;
    localparam int OP3_MSB    = 7;
    localparam int OP3_LSB    = 4;
    localparam int DBACK_MSB  = 3;
    localparam int DBACK_LSB  = 0;

    localparam int OP1_W   = OP1_MSB - OP1_LSB + 1;
    localparam int RA_W    = RA_MSB - RA_LSB + 1;
    localparam int RD_W    = RD_MSB - RD_LSB + 1;
    localparam int OP3_W   = OP3_MSB - OP3_LSB + 1;
    localparam int DBACK_W = DBACK_MSB - DBACK_LSB + 1;

    typedef struct packed {
        logic [OP1_W-1:0]   op1;
        logic [RA_W-1:0]    rs_ra_op2;
        logic [RD_W-1:0]    rd_rb_cond;
        logic [OP3_W-1:0]   op3_dfront;
        logic [DBACK_W-1:0] dback;
    } code_fields_t;

endpackage

// File: rtl/code_queue_if.sv
// code_queue_if: fetch-side and decode-side handshake bundle of the
// instruction queue.
//   fetch side : in_valid, in_code, in_pc -> queue ; in_ready <- queue
//   decode side: out_ready -> queue ; out_valid, code_out, pc_out,
//                the five split fields and count <- queue
// master is the surrounding pipeline's view, slave is the queue's view.
interface code_queue_if #(
    parameter int DEPTH = 4,
    parameter int PCW   = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [code_pkg::IW-1:0]  in_code;
    logic [PCW-1:0]           in_pc;

    logic                     out_valid;
    logic                     out_ready;
    logic [code_pkg::IW-1:0]  code_out;
    logic [PCW-1:0]           pc_out;
    logic [1:0]               op1_out;
    logic [2:0]               Rs_Ra_op2_out;
    logic [2:0]               Rd_Rb_cond_out;
    logic [3:0]               op3_dFront_out;
    logic [3:0]               dBack_out;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_code, in_pc, out_ready,
        input  in_ready, out_valid, code_out, pc_out, op1_out,
               Rs_Ra_op2_out, Rd_Rb_cond_out, op3_dFront_out, dBack_out, count
    );

    modport slave (
        input  in_valid, in_code, in_pc, out_ready,
        output in_ready, out_valid, code_out, pc_out, op1_out,
               Rs_Ra_op2_out, Rd_Rb_cond_out, op3_dFront_out, dBack_out, count
    );
endinterface

// File: rtl/code_queue_fields.sv
// code_fields: purely combinational split of a 16-bit instruction word
// into its five fields. Shared with decode.
//   code   in  : instruction word
//   fields out : op1 / Rs_Ra_op2 / Rd_Rb_cond / op3_dFront / dBack
module code_fields
    import code_pkg::*;
(
    input  logic [IW-1:0] code,
    output code_fields_t  fields
);

    // Plain bit slicing; positions come from the shared package so decode
    // and the queue can never disagree on the layout.
    always_comb begin
        fields            = '0;
        fields.op1        = code[OP1_MSB:OP1_LSB];
        fields.rs_ra_op2  = code[RA_MSB:RA_LSB];
        fields.rd_rb_cond = code[RD_MSB:RD_LSB];
        fields.op3_dfront = code[OP3_MSB:OP3_LSB];
        fields.dback      = code[DBACK_MSB:DBACK_LSB];
    end

endmodule

// File: rtl/code_queue.sv
// code_queue: DEPTH-entry first-word-fall-through instruction buffer
// between fetch and decode, carrying each word with its PC.
//   clock : rising-edge clock
//   reset : synchronous active-high, empties the queue
//   flush : empties the queue (taken branch / redirect)
//   bus   : code_queue_if slave view (fetch push side, decode pop side,
//           head word/PC, head split into fields, occupancy count)
module code_queue
    import code_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PCW   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       flush,
    code_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [IW-1:0]  code_mem [DEPTH];
    logic [PCW-1:0] pc_mem   [DEPTH];
    logic [AW-1:0]  wp;
    logic [AW-1:0]  rp;
    logic [CW-1:0]  count_q;

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           clear;
    logic [IW-1:0]  head_code;
    logic [PCW-1:0] head_pc;
    code_fields_t   head_fields;

    // in_ready is derived from the count only, so decode's out_ready never
    // reaches fetch combinationally. A push while full is therefore refused
    // even if decode pops in the same cycle.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = bus.out_ready & ~empty;
    assign clear = reset | flush;

    // Pointers and occupancy. Reset and flush are the same operation and
    // override any push/pop in that cycle. Pointers are AW bits so they wrap
    // modulo DEPTH on their own.
    always_ff @(posedge clock) begin
        if (clear) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not cleared by reset; stale contents are hidden by the
    // empty masking on the outputs. A push dropped by flush/reset must not
    // write either.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            code_mem[wp] <= bus.in_code;
            pc_mem[wp]   <= bus.in_pc;
        end
    end

    // Head is forced to zero while empty so decode sees op1=00 and all
    // fields clear rather than leftover data.
    assign head_code = empty ? '0 : code_mem[rp];
    assign head_pc   = empty ? '0 : pc_mem[rp];

    code_fields u_fields (
        .code   (head_code),
        .fields (head_fields)
    );

    assign bus.in_ready       = ~full;
    assign bus.out_valid      = ~empty;
    assign bus.code_out       = head_code;
    assign bus.pc_out         = head_pc;
    assign bus.op1_out        = head_fields.op1;
    assign bus.Rs_Ra_op2_out  = head_fields.rs_ra_op2;
    assign bus.Rd_Rb_cond_out = head_fields.rd_rb_cond;
    assign bus.op3_dFront_out = head_fields.op3_dfront;
    assign bus.dBack_out      = head_fields.dback;
    assign bus.count          = count_q;

endmodule

// File: tb/tb_code_queue.sv
// tb_code_queue: self-checking bench for code_queue (DEPTH=4, PCW=16).
// A queue model serves as scoreboard: entries are pushed when an accepted
// push is driven and popped and compared when decode consumes the head.
module tb_code_queue;
    import code_pkg::*;

    localparam int DEPTH = 4;
    localparam int PCW   = 16;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    code_queue_if #(.DEPTH(DEPTH), .PCW(PCW)) bus ();

    code_queue #(.DEPTH(DEPTH), .PCW(PCW)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0]    code;
        logic [PCW-1:0] pc;
    } entry_t;

    typedef struct {
        logic           v;
        logic [15:0]    code;
        logic [PCW-1:0] pc;
        logic           rdy;
        int             exp_count;
        logic           exp_valid;
        logic           exp_ready;
        logic [15:0]    exp_code;
    } vec_t;

    entry_t model_q[$];
    vec_t   vectors[11];
    int     errors = 0;
    int     checks = 0;

    // One comparison: counted, and reported on mismatch.
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Compare every DUT output with what the scoreboard says is held.
    task automatic checkOutput();
        logic [15:0]    c;
        logic [PCW-1:0] p;
        c = 16'h0;
        p = '0;
        if (model_q.size() != 0) begin
            c = model_q[0].code;
            p = model_q[0].pc;
        end
        check("out_valid",  32'(bus.out_valid),      32'(model_q.size() != 0));
        check("in_ready",   32'(bus.in_ready),       32'(model_q.size() < DEPTH));
        check("count",      32'(bus.count),          32'(model_q.size()));
        check("code_out",   32'(bus.code_out),       32'(c));
        check("pc_out",     32'(bus.pc_out),         32'(p));
        check("op1",        32'(bus.op1_out),        32'(c[15:14]));
        check("Rs_Ra_op2",  32'(bus.Rs_Ra_op2_out),  32'(c[13:11]));
        check("Rd_Rb_cond", 32'(bus.Rd_Rb_cond_out), 32'(c[10:8]));
        check("op3_dFront", 32'(bus.op3_dFront_out), 32'(c[7:4]));
        check("dBack",      32'(bus.dBack_out),      32'(c[3:0]));
    endtask

    // Drive one cycle, score any pop before the edge, update the model
    // after the edge, then check all outputs.
    task automatic applyStimulus(input logic v, input logic [15:0] code, input logic [PCW-1:0] pc,
                                 input logic rdy, input logic fl, input logic rs);
        bit     do_push;
        bit     do_pop;
        entry_t exp;
        bus.in_valid  = v;
        bus.in_code   = code;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        flush         = fl;
        reset         = rs;
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = rdy && (model_q.size() != 0);
        #1;
        if (!rs && !fl && do_pop) begin
            exp = model_q.pop_front();
            check("pop_code", 32'(bus.code_out), 32'(exp.code));
            check("pop_pc",   32'(bus.pc_out),   32'(exp.pc));
        end
        @(posedge clock);
        #1;
        if (rs || fl) model_q.delete();
        else if (do_push) model_q.push_back('{code, pc});
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Fill four, try a fifth while full, drain, pop while empty, then
        // load the field-split word.
        vectors[0]  = '{1'b1, 16'h1111, 16'h0100, 1'b0, 1, 1'b1, 1'b1, 16'h1111};
        vectors[1]  = '{1'b1, 16'h2222, 16'h0102, 1'b0, 2, 1'b1, 1'b1, 16'h1111};
        vectors[2]  = '{1'b1, 16'h3333, 16'h0104, 1'b0, 3, 1'b1, 1'b1, 16'h1111};
        vectors[3]  = '{1'b1, 16'h4444, 16'h0106, 1'b0, 4, 1'b1, 1'b0, 16'h1111};
        vectors[4]  = '{1'b1, 16'h5555, 16'h0108, 1'b0, 4, 1'b1, 1'b0, 16'h1111};
        vectors[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 3, 1'b1, 1'b1, 16'h2222};
        vectors[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 2, 1'b1, 1'b1, 16'h3333};
        vectors[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1, 1'b1, 1'b1, 16'h4444};
        vectors[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 0, 1'b0, 1'b1, 16'h0000};
        vectors[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 0, 1'b0, 1'b1, 16'h0000};
        vectors[10] = '{1'b1, 16'hB5A3, 16'h0010, 1'b0, 1, 1'b1, 1'b1, 16'hB5A3};

        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        reset         = 1'b0;

        // Reset then idle.
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Table-driven vectors.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vectors[i].v, vectors[i].code, vectors[i].pc, vectors[i].rdy, 1'b0, 1'b0);
            check($sformatf("vec%0d_count", i), 32'(bus.count),     32'(vectors[i].exp_count));
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vectors[i].exp_valid));
            check($sformatf("vec%0d_ready", i), 32'(bus.in_ready),  32'(vectors[i].exp_ready));
            check($sformatf("vec%0d_code", i),  32'(bus.code_out),  32'(vectors[i].exp_code));
        end

        // Explicit field split of 16'hB5A3.
        check("b5a3_op1",   32'(bus.op1_out),        32'(2'b10));
        check("b5a3_ra",    32'(bus.Rs_Ra_op2_out),  32'(3'b110));
        check("b5a3_rd",    32'(bus.Rd_Rb_cond_out), 32'(3'b101));
        check("b5a3_op3",   32'(bus.op3_dFront_out), 32'(4'hA));
        check("b5a3_dback", 32'(bus.dBack_out),      32'(4'h3));
        check("b5a3_pc",    32'(bus.pc_out),         32'(16'h0010));
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);

        // Sustained push+pop at count=1 across two pointer wraps.
        applyStimulus(1'b1, 16'hC000, 16'h0200, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 16'hC000 + 16'(i), 16'h0200 + 16'(2 * i), 1'b1, 1'b0, 1'b0);
            check($sformatf("stream%0d_count", i), 32'(bus.count), 32'd1);
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);

        // Flush at count=3 with a push in the same cycle.
        applyStimulus(1'b1, 16'h7001, 16'h0300, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h7002, 16'h0302, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h7003, 16'h0304, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hDEAD, 16'h0306, 1'b0, 1'b1, 1'b0);
        check("flush_count", 32'(bus.count),     32'd0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b1, 16'h0A0A, 16'h0400, 1'b0, 1'b0, 1'b0);
        check("postflush_head", 32'(bus.code_out), 32'(16'h0A0A));
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);

        // Reset together with flush, push and pop at count=2.
        applyStimulus(1'b1, 16'h8001, 16'h0500, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h8002, 16'h0502, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hBEEF, 16'h0504, 1'b1, 1'b1, 1'b1);
        check("reset_count", 32'(bus.count),    32'd0);
        check("reset_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b1, 16'h0F0F, 16'h0600, 1'b0, 1'b0, 1'b0);
        check("postreset_count", 32'(bus.count), 32'd1);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
